pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the MIPS core. It generalises the fixed-field EX/MEM latch into one reusable stage.
- Carries a control field and a payload field under a valid/ready handshake, with optional two-entry skid buffering, synchronous flush and bubble semantics.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB. A blocked stage stalls upstream without losing or duplicating instructions.

Parameters:
- CTRL_W, 9: width of control field (jump, branch, memRead, memToReg, memWrite, regWrite); forced to zero in bubbles.
- DATA_W, 134: width of payload (fourPC, zero, aluResult, readData2, writeDataReg, instruction); never forced.
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all held entries (branch/jump redirect)
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream consumes this cycle
- out_ctrl  out  CTRL_W  control field; all-zero whenever out_valid=0
- out_data  out  DATA_W  payload
- stall_cnt  out  CNT_W  saturating count of stalled output cycles

Behaviour:
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready. All state updates occur on posedge clk.
- Reset (rst=1 at an edge), highest priority:
  - state EMPTY; out_valid=0, out_ctrl=0, out_data=0.
  - skid contents=0, stall_cnt=0.
  - in_ready=1 in the cycle after reset.
- Flush (rst=0, flush=1):
  - Next state EMPTY; out_valid=0, out_ctrl=0, in_ready=1.
  - Any entry accepted in the same cycle is discarded.
  - out_data and skid data keep their old values.
  - stall_cnt is unchanged.
- Latency: 1 cycle. An entry accepted at edge N is presented on out_* after edge N.
- SKID_EN=1, states EMPTY / ONE / TWO (main register, then main+skid); in_ready is a register, =1 except in TWO:
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept & consume -> ONE, main<=in.
  - ONE: accept & !consume -> TWO, skid<=in, in_ready=0 next cycle.
  - ONE: !accept & consume -> EMPTY.
  - ONE: neither -> hold.
  - TWO: consume -> ONE, main<=skid, in_ready=1 next cycle.
  - TWO: !consume -> hold. No accept is possible in TWO.
- SKID_EN=0: states EMPTY / ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - accept -> main<=in; consume without accept -> EMPTY.
- Ordering: strict FIFO. Every accepted entry is presented exactly once unless flushed.
- Stability: while out_valid & !out_ready, out_ctrl and out_data hold constant.
- Bubble: out_ctrl=0 whenever out_valid=0. Downstream regWrite/memWrite can never fire on a bubble.
- stall_cnt: +1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by rst.
- Simultaneous rst & flush: reset wins.
- in_ctrl/in_data are ignored unless accept.

Test Plan:
- Reset/bubble: rst=1 for 2 cycles with in_valid=1, in_ctrl=9'h1FF -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0. in_ready=1 the cycle after rst falls.
- Streaming, out_ready=1: drive data 0x10,0x11,0x12 on consecutive cycles -> the same values appear one cycle later, back-to-back, in_ready stays 1.
- Skid fill (SKID_EN=1): out_ready=0, send A=0xA, B=0xB.
  - in_ready=0 after B is accepted; out_data holds 0xA.
  - stall_cnt increments each cycle.
  - Raise out_ready: A, then B, with no loss; in_ready returns to 1.
- Flush in TWO with in_valid=1, C=0xC: next cycle out_valid=0, out_ctrl=0, in_ready=1. A, B and C never appear.
- SKID_EN=0 stall: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> replace in one cycle, no bubble.
- stall_cnt saturation with CNT_W=4: hold out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Reusable inter-stage pipeline register for the MIPS core (IF/ID, ID/EX,
//   EX/MEM, MEM/WB). It moves a control field and a payload field across a
//   valid/ready handshake. Optionally, it adds a two-entry skid buffer so that
//   in_ready can be a register. It also supports synchronous flush and bubble
//   insertion.
//
// Parameters
//   CTRL_W  : control field width; the field is forced to zero in bubbles
//   DATA_W  : payload width; the payload is never forced
//   SKID_EN : 1 = main + skid register with registered in_ready
//             0 = single register with combinational in_ready
//   CNT_W   : width of the saturating stall-cycle counter
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   flush               : squash every held entry (branch/jump redirect)
//   in_valid / in_ready : upstream handshake
//   in_ctrl / in_data   : upstream control field and payload
//   out_valid/out_ready : downstream handshake
//   out_ctrl / out_data : presented entry; out_ctrl is zero when out_valid=0
//   stall_cnt           : number of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int CTRL_W  = 9,
   parameter int DATA_W  = 134,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q;
   logic              out_valid_q;
   logic              in_ready_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic accept;
   logic consume;
   logic stalled;

   // in_ready is a register only when the skid entry exists. Without the
   // skid entry, the stage accepts whenever its single slot frees up in the
   // same cycle.
   generate
      if (SKID_EN != 0) begin : g_skid
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign in_ready = !out_valid_q | out_ready;
      end
   endgenerate

   assign accept    = in_valid & in_ready;
   assign consume   = out_valid_q & out_ready;
   assign stalled   = out_valid_q & !out_ready;

   assign out_valid = out_valid_q;
   assign out_ctrl  = main_ctrl_q;   // kept zero by every transition into EMPTY
   assign out_data  = main_data_q;
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         stall_cnt_q <= '0;
      end else if (flush) begin
         // Payload registers keep their contents. Only the control field
         // is cleared, so the bubble cannot fire downstream side effects.
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
      end else begin
         if (stalled && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end

         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
                  main_ctrl_q <= in_ctrl;
                  main_data_q <= in_data;
               end
            end

            ONE: begin
               if (accept && consume) begin
                  main_ctrl_q <= in_ctrl;
                  main_data_q <= in_data;
               end else if (accept) begin
                  // Only reachable with the skid entry present. Without it,
                  // an accept while full implies out_ready, which is a consume.
                  state_q     <= TWO;
                  in_ready_q  <= 1'b0;
                  skid_ctrl_q <= in_ctrl;
                  skid_data_q <= in_data;
               end else if (consume) begin
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
                  main_ctrl_q <= '0;
               end
            end

            TWO: begin
               if (consume) begin
                  state_q     <= ONE;
                  in_ready_q  <= 1'b1;
                  main_ctrl_q <= skid_ctrl_q;
                  main_data_q <= skid_data_q;
               end
            end

            default: begin
               state_q     <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               main_ctrl_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int CW = 9;
   localparam int DW = 134;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT a: skid buffer, 16-bit counter
   logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
   logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
   logic [DW-1:0] a_in_data = '0, a_out_data;
   logic [15:0]   a_stall_cnt;

   // DUT b: no skid buffer
   logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
   logic [CW-1:0] b_in_ctrl = '0, b_out_ctrl;
   logic [DW-1:0] b_in_data = '0, b_out_data;
   logic [15:0]   b_stall_cnt;

   // DUT c: 4-bit counter for saturation
   logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
   logic [CW-1:0] c_in_ctrl = '0, c_out_ctrl;
   logic [DW-1:0] c_in_data = '0, c_out_data;
   logic [3:0]    c_stall_cnt;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .stall_cnt(a_stall_cnt));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .stall_cnt(b_stall_cnt));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(4)) u_c (
      .clk(clk), .rst(rst), .flush(c_flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ctrl(c_in_ctrl), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
      .stall_cnt(c_stall_cnt));

   int pass_cnt  = 0;
   int total_cnt = 0;
   ent_t qa[$];
   ent_t qb[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
         $display("ok   %s = %0h", name, act);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard push: the expected output of every accepted entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_flush) qa.delete();
         else if (a_in_valid && a_in_ready) qa.push_back('{c: a_in_ctrl, d: a_in_data});
         if (b_flush) qb.delete();
         else if (b_in_valid && b_in_ready) qb.push_back('{c: b_in_ctrl, d: b_in_data});
      end
   end

   // Monitor: pop and compare on every consumed output.
   always @(negedge clk) begin
      ent_t e;
      if (!rst && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            check("a_unexpected_output", a_out_data, '1);
         end else begin
            e = qa.pop_front();
            check("a_out_ctrl", DW'(a_out_ctrl), DW'(e.c));
            check("a_out_data", a_out_data, e.d);
         end
      end
      if (!rst && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            check("b_unexpected_output", b_out_data, '1);
         end else begin
            e = qb.pop_front();
            check("b_out_ctrl", DW'(b_out_ctrl), DW'(e.c));
            check("b_out_data", b_out_data, e.d);
         end
      end
   end

   initial begin
      // ---------------- reset with junk on the inputs ----------------
      a_in_valid = 1; a_in_ctrl = 9'h1FF; a_in_data = 'h55;
      @(negedge clk);
      check("rst_out_valid", DW'(a_out_valid), 0);
      check("rst_out_ctrl", DW'(a_out_ctrl), 0);
      check("rst_out_data", a_out_data, 0);
      check("rst_stall_cnt", DW'(a_stall_cnt), 0);
      @(posedge clk); #1;
      rst = 0; a_in_valid = 0; a_in_ctrl = '0;
      @(negedge clk);
      check("post_rst_in_ready", DW'(a_in_ready), 1);
      check("post_rst_out_valid", DW'(a_out_valid), 0);
      tick();

      // ---------------- streaming with out_ready=1 ----------------
      a_out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1; a_in_data = DW'(8'h10 + i); a_in_ctrl = CW'(i + 1);
         @(negedge clk);
         check("stream_in_ready", DW'(a_in_ready), 1);
         if (i > 0) check("stream_latency_data", a_out_data, DW'(8'h10 + i - 1));
         tick();
      end
      a_in_valid = 0;
      @(negedge clk);
      check("stream_last_data", a_out_data, 'h12);
      tick();
      @(negedge clk);
      check("stream_bubble_valid", DW'(a_out_valid), 0);
      check("stream_bubble_ctrl", DW'(a_out_ctrl), 0);
      tick();

      // ---------------- skid fill ----------------
      a_out_ready = 0;
      a_in_valid = 1; a_in_data = 'hA; a_in_ctrl = 9'h00A;
      tick();
      a_in_data = 'hB; a_in_ctrl = 9'h00B;
      @(negedge clk);
      check("skid_one_in_ready", DW'(a_in_ready), 1);
      check("skid_one_data", a_out_data, 'hA);
      check("skid_stall0", DW'(a_stall_cnt), 0);
      tick();
      a_in_valid = 0;
      @(negedge clk);
      check("skid_two_in_ready", DW'(a_in_ready), 0);
      check("skid_two_hold_data", a_out_data, 'hA);
      check("skid_stall1", DW'(a_stall_cnt), 1);
      tick();
      @(negedge clk);
      check("skid_two_hold_ctrl", DW'(a_out_ctrl), 'h00A);
      check("skid_stall2", DW'(a_stall_cnt), 2);
      a_out_ready = 1;
      tick();
      @(negedge clk);
      check("skid_drain_in_ready", DW'(a_in_ready), 1);
      check("skid_drain_data_b", a_out_data, 'hB);
      check("skid_stall_held", DW'(a_stall_cnt), 2);
      tick();
      @(negedge clk);
      check("skid_empty", DW'(a_out_valid), 0);
      tick();

      // ---------------- flush while in TWO ----------------
      a_out_ready = 0;
      a_in_valid = 1; a_in_data = 'hA; a_in_ctrl = 9'h0A1;
      tick();
      a_in_data = 'hB; a_in_ctrl = 9'h0B1;
      tick();
      a_in_data = 'hC; a_in_ctrl = 9'h0C1; a_flush = 1;
      tick();
      a_flush = 0; a_in_valid = 0;
      @(negedge clk);
      check("flush_out_valid", DW'(a_out_valid), 0);
      check("flush_out_ctrl", DW'(a_out_ctrl), 0);
      check("flush_in_ready", DW'(a_in_ready), 1);
      check("flush_data_kept", a_out_data, 'hA);
      a_out_ready = 1;
      repeat (3) tick();
      @(negedge clk);
      check("flush_nothing_left", DW'(a_out_valid), 0);

      // ---------------- no-skid stall and replace ----------------
      b_out_ready = 0;
      b_in_valid = 1; b_in_data = 'h21; b_in_ctrl = 9'h021;
      tick();
      b_in_data = 'h22; b_in_ctrl = 9'h022;
      @(negedge clk);
      check("noskid_out_valid", DW'(b_out_valid), 1);
      check("noskid_in_ready_low", DW'(b_in_ready), 0);
      tick();
      @(negedge clk);
      check("noskid_hold_data", b_out_data, 'h21);
      b_out_ready = 1;
      #1;
      check("noskid_in_ready_comb", DW'(b_in_ready), 1);
      tick();
      b_in_valid = 0;
      @(negedge clk);
      check("noskid_replace_valid", DW'(b_out_valid), 1);
      check("noskid_replace_data", b_out_data, 'h22);
      tick();
      @(negedge clk);
      check("noskid_empty", DW'(b_out_valid), 0);

      // ---------------- stall counter saturation (CNT_W=4) ----------------
      c_out_ready = 0;
      c_in_valid = 1; c_in_data = 'h33; c_in_ctrl = 9'h033;
      tick();
      c_in_valid = 0;
      repeat (20) tick();
      @(negedge clk);
      check("sat_stall_cnt", DW'(c_stall_cnt), 15);
      tick();
      @(negedge clk);
      check("sat_stall_cnt_hold", DW'(c_stall_cnt), 15);
      check("sat_data_hold", c_out_data, 'h33);

      // ---------------- leftovers ----------------
      check("a_scoreboard_empty", DW'(qa.size()), 0);
      check("b_scoreboard_empty", DW'(qb.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
